maze_move_checker: RTL and testbench



---
 rtl/maze_pkg.sv | 33 +++
 rtl/maze_move_checker_if.sv | 31 +++
 rtl/maze_edge_scan.sv | 88 ++++++++
 rtl/maze_move_checker.sv | 225 ++++++++++++++++++++++
 tb/tb_maze_move_checker.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze move checker.
// Maze geometry, direction encoding, colour defaults, FSM state codes and
// the pixel-index helper shared by the checker and its edge scanner.
package maze_pkg;

    localparam int MAZE_W = 96;
    localparam int MAZE_H = 64;

    localparam logic [15:0] WALL_COLOR_DEF = 16'hFFFF;
    localparam logic [15:0] GOAL_COLOR_DEF = 16'h07E0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_BOUNDS = 2'd1;
    localparam state_t ST_SCAN   = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // index = y*96 + x, with the multiply done as two shifts
    function automatic logic [12:0] pix_index(input logic [6:0] x, input logic [5:0] y);
        logic [12:0] y13;
        y13 = {7'd0, y};
        return (y13 << 6) + (y13 << 5) + {6'd0, x};
    endfunction

endpackage

// File: rtl/maze_move_checker_if.sv
// Bus between the move controller / maze ROM and the move checker.
//   req, dir, px, py   : move request and current sprite position
//   rom_index, rom_data: pixel address out, registered ROM word back
//   busy, done, move_ok, new_x, new_y, at_goal : status and result
// master = controller/ROM side, slave = checker side.
interface maze_move_checker_if;

    logic        req;
    logic [1:0]  dir;
    logic [6:0]  px;
    logic [5:0]  py;
    logic [12:0] rom_index;
    logic [15:0] rom_data;
    logic        busy;
    logic        done;
    logic        move_ok;
    logic [6:0]  new_x;
    logic [5:0]  new_y;
    logic        at_goal;

    modport master (
        output req, dir, px, py, rom_data,
        input  rom_index, busy, done, move_ok, new_x, new_y, at_goal
    );

    modport slave (
        input  req, dir, px, py, rom_data,
        output rom_index, busy, done, move_ok, new_x, new_y, at_goal
    );

endinterface

// File: rtl/maze_edge_scan.sv
// Edge pixel index generator for the move checker.
// Walks the PSIZE pixels of the edge just beyond the sprite in direction
// dir, in increasing x (up/down) or increasing y (left/right).
//   start   : reload the walk at offset 0
//   step    : advance to the next pixel (ignored once the walk is finished)
//   index   : pixel index of the current offset
//   last    : current offset is the final one
//   running : walk still has pixels left to step through
module maze_edge_scan
    import maze_pkg::*;
#(
    parameter int PSIZE = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  dir_e        dir,
    input  logic [6:0]  px,
    input  logic [5:0]  py,
    output logic [12:0] index,
    output logic        last,
    output logic        running
);

    localparam int CW = $clog2(PSIZE + 1);

    logic [CW-1:0] rem_q, rem_d;
    logic          run_q, run_d;
    logic [5:0]    off;
    logic [6:0]    ex;
    logic [5:0]    ey;

    // remaining-pixel down-counter; terminal count marks the last pixel
    always_comb begin
        rem_d = rem_q;
        run_d = run_q;
        if (start) begin
            rem_d = CW'(PSIZE - 1);
            run_d = 1'b1;
        end else if (step && run_q) begin
            if (rem_q == '0) begin
                run_d = 1'b0;
            end else begin
                rem_d = rem_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            run_q <= run_d;
        end
    end

    always_comb begin
        off = 6'(PSIZE - 1) - 6'(rem_q);
        ex  = px;
        ey  = py;
        case (dir)
            DIR_UP: begin
                ex = px + {1'b0, off};
                ey = py - 6'd1;
            end
            DIR_DOWN: begin
                ex = px + {1'b0, off};
                ey = py + 6'(PSIZE);
            end
            DIR_LEFT: begin
                ex = px - 7'd1;
                ey = py + off;
            end
            default: begin
                ex = px + 7'(PSIZE);
                ey = py + off;
            end
        endcase
    end

    assign index   = pix_index(ex, ey);
    assign last    = (rem_q == '0);
    assign running = run_q;

endmodule

// File: rtl/maze_move_checker.sv
// Maze move checker: decides whether the player sprite may move one pixel
// in the requested direction by reading the edge just beyond the sprite
// from the maze ROM and looking for wall pixels.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : maze_move_checker_if.slave (request, ROM port, result)
// Optional build macro MAZE_GOAL_DETECT_EN: also flags goal-coloured pixels
// on the scanned edge and reports at_goal with an allowed move; without it
// at_goal is tied low.
//
// state  | meaning
// IDLE   | waiting for req; request fields latched on accept
// BOUNDS | check the target edge lies inside the maze, first index issued
// SCAN   | issue remaining edge indices, compare returned words
// DONE   | register result, pulse done
module maze_move_checker
    import maze_pkg::*;
#(
    parameter int          PSIZE      = 9,
    parameter logic [15:0] WALL_COLOR = WALL_COLOR_DEF,
    parameter logic [15:0] GOAL_COLOR = GOAL_COLOR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    maze_move_checker_if.slave bus
);

    state_t      state_q, state_d;
    dir_e        dir_q, dir_d;
    logic [6:0]  px_q, px_d;
    logic [5:0]  py_q, py_d;
    logic        hit_q, hit_d;
    logic        iss_q, iss_d;
    logic        iss_last_q, iss_last_d;
    logic        rdv_q, rdv_d;
    logic        rdv_last_q, rdv_last_d;
    logic [12:0] rom_index_q, rom_index_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        move_ok_q, move_ok_d;
    logic [6:0]  new_x_q, new_x_d;
    logic [5:0]  new_y_q, new_y_d;

    logic        in_bounds;
    logic        scan_start;
    logic        scan_step;
    logic [12:0] scan_index;
    logic        scan_last;
    logic        scan_run;

    maze_edge_scan #(.PSIZE(PSIZE)) u_scan (
        .clk     (clk),
        .reset   (reset),
        .start   (scan_start),
        .step    (scan_step),
        .dir     (dir_q),
        .px      (px_q),
        .py      (py_q),
        .index   (scan_index),
        .last    (scan_last),
        .running (scan_run)
    );

    always_comb begin
        case (dir_q)
            DIR_UP:   in_bounds = (py_q != 6'd0);
            DIR_DOWN: in_bounds = (({1'b0, py_q} + 7'(PSIZE)) <= 7'(MAZE_H - 1));
            DIR_LEFT: in_bounds = (px_q != 7'd0);
            default:  in_bounds = (({1'b0, px_q} + 8'(PSIZE)) <= 8'(MAZE_W - 1));
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        px_d        = px_q;
        py_d        = py_q;
        hit_d       = hit_q;
        iss_d       = 1'b0;
        iss_last_d  = 1'b0;
        // ROM is registered: the word for an index arrives one cycle later
        rdv_d       = iss_q;
        rdv_last_d  = iss_last_q;
        rom_index_d = rom_index_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        move_ok_d   = move_ok_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        scan_start  = 1'b0;
        scan_step   = 1'b0;

        if (rdv_q && (bus.rom_data == WALL_COLOR)) begin
            hit_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    dir_d      = dir_e'(bus.dir);
                    px_d       = bus.px;
                    py_d       = bus.py;
                    hit_d      = 1'b0;
                    busy_d     = 1'b1;
                    scan_start = 1'b1;
                    state_d    = ST_BOUNDS;
                end
            end
            ST_BOUNDS: begin
                if (in_bounds) begin
                    scan_step = 1'b1;
                    state_d   = ST_SCAN;
                end else begin
                    // off-maze target counts as blocked, no ROM traffic
                    hit_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_SCAN: begin
                scan_step = scan_run;
                if (rdv_last_q) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                move_ok_d = !hit_q;
                new_x_d   = px_q;
                new_y_d   = py_q;
                if (!hit_q) begin
                    case (dir_q)
                        DIR_UP:   new_y_d = py_q - 6'd1;
                        DIR_DOWN: new_y_d = py_q + 6'd1;
                        DIR_LEFT: new_x_d = px_q - 7'd1;
                        default:  new_x_d = px_q + 7'd1;
                    endcase
                end
                state_d = ST_IDLE;
            end
        endcase

        if (scan_step) begin
            rom_index_d = scan_index;
            iss_d       = 1'b1;
            iss_last_d  = scan_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_UP;
            px_q        <= '0;
            py_q        <= '0;
            hit_q       <= 1'b0;
            iss_q       <= 1'b0;
            iss_last_q  <= 1'b0;
            rdv_q       <= 1'b0;
            rdv_last_q  <= 1'b0;
            rom_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            move_ok_q   <= 1'b0;
            new_x_q     <= '0;
            new_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            px_q        <= px_d;
            py_q        <= py_d;
            hit_q       <= hit_d;
            iss_q       <= iss_d;
            iss_last_q  <= iss_last_d;
            rdv_q       <= rdv_d;
            rdv_last_q  <= rdv_last_d;
            rom_index_q <= rom_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            move_ok_q   <= move_ok_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
        end
    end

`ifdef MAZE_GOAL_DETECT_EN
    logic goal_q, goal_d;
    logic at_goal_q, at_goal_d;

    always_comb begin
        goal_d    = goal_q;
        at_goal_d = at_goal_q;
        if (state_q == ST_IDLE && bus.req) begin
            goal_d = 1'b0;
        end else if (rdv_q && (bus.rom_data == GOAL_COLOR)) begin
            goal_d = 1'b1;
        end
        if (state_q == ST_DONE) begin
            at_goal_d = goal_q && !hit_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            goal_q    <= 1'b0;
            at_goal_q <= 1'b0;
        end else begin
            goal_q    <= goal_d;
            at_goal_q <= at_goal_d;
        end
    end

    assign bus.at_goal = at_goal_q;
`else
    assign bus.at_goal = 1'b0;
`endif

    assign bus.rom_index = rom_index_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.move_ok   = move_ok_q;
    assign bus.new_x     = new_x_q;
    assign bus.new_y     = new_y_q;

endmodule

// File: tb/tb_maze_move_checker.sv
module tb_maze_move_checker;
    import maze_pkg::*;

    localparam int PS = 9;
`ifdef MAZE_GOAL_DETECT_EN
    localparam int GOAL_ON = 1;
`else
    localparam int GOAL_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maze_move_checker_if bus();

    maze_move_checker #(.PSIZE(PS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [0:8191];
    always @(posedge clk) bus.rom_data <= mem[bus.rom_index];

    int checks   = 0;
    int failures = 0;
    int exp_reads[$];

    typedef struct {
        int d; int x; int y; int inj;
        int ok; int nx; int ny; int lat; int goal;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: walk the edge beyond the sprite, look up the maze image.
    task automatic model(input int d, input int x, input int y,
                         output int ok, output int nx, output int ny,
                         output int lat, output int goal);
        int dx, dy, ex, ey, sx, sy, wall, g, a;
        dx = 0; dy = 0;
        case (d)
            0: dy = -1;
            1: dy = 1;
            2: dx = -1;
            default: dx = 1;
        endcase
        if (dy != 0) begin
            ex = x; ey = (dy < 0) ? y - 1 : y + PS; sx = 1; sy = 0;
        end else begin
            ex = (dx < 0) ? x - 1 : x + PS; ey = y; sx = 0; sy = 1;
        end
        exp_reads.delete();
        ok = 0; nx = x; ny = y; lat = 2; goal = 0;
        if (ex >= 0 && ey >= 0 && ex + sx*(PS-1) <= 95 && ey + sy*(PS-1) <= 63) begin
            wall = 0; g = 0;
            for (int k = 0; k < PS; k++) begin
                a = (ey + sy*k) * 96 + (ex + sx*k);
                exp_reads.push_back(a);
                if (mem[a] == 16'hFFFF) wall = 1;
                if (mem[a] == 16'h07E0) g = 1;
            end
            lat = PS + 3;
            ok = !wall;
            if (ok != 0) begin nx = x + dx; ny = y + dy; end
            goal = (GOAL_ON != 0 && ok != 0 && g != 0) ? 1 : 0;
        end
    endtask

    task automatic run_move(input string tag, input int d, input int x, input int y,
                            input int inj, input int eok, input int enx, input int eny,
                            input int elat, input int egoal);
        int prev_idx, lat, bad, busy_bad, extra;
        @(negedge clk);
        bus.req = 1'b1; bus.dir = 2'(d); bus.px = 7'(x); bus.py = 6'(y);
        prev_idx = int'(bus.rom_index);
        @(negedge clk);
        bus.req = 1'b0;
        chk({tag, "_busy_set"}, int'(bus.busy), 1);
        lat = -1; bad = 0; busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == inj) begin bus.req = 1'b1; bus.dir = 2'((d + 1) % 4); end
            if (c == inj + 1) bus.req = 1'b0;
            if (elat > 2 && c <= PS && int'(bus.rom_index) != exp_reads[c-1]) bad++;
            if (elat == 2 && int'(bus.rom_index) != prev_idx) bad++;
            if (bus.done) begin lat = c; break; end
            if (!bus.busy) busy_bad++;
        end
        bus.req = 1'b0;
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_reads"}, bad, 0);
        chk({tag, "_busy_hold"}, busy_bad, 0);
        if (lat > 0) begin
            chk({tag, "_move_ok"}, int'(bus.move_ok), eok);
            chk({tag, "_new_x"}, int'(bus.new_x), enx);
            chk({tag, "_new_y"}, int'(bus.new_y), eny);
            chk({tag, "_at_goal"}, int'(bus.at_goal), egoal);
            chk({tag, "_busy_clr"}, int'(bus.busy), 0);
        end
        extra = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
            if (int'(bus.move_ok) != eok || int'(bus.new_x) != enx || int'(bus.new_y) != eny) extra++;
        end
        chk({tag, "_post_done"}, extra, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_index"}, int'(bus.rom_index), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_move_ok"}, int'(bus.move_ok), 0);
        chk({tag, "_new_x"}, int'(bus.new_x), 0);
        chk({tag, "_new_y"}, int'(bus.new_y), 0);
        chk({tag, "_at_goal"}, int'(bus.at_goal), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok, nx, ny, lat, goal, d, x, y, r, dones;
        reset = 1'b1;
        bus.req = 1'b0; bus.dir = 2'd0; bus.px = 7'd0; bus.py = 6'd0;
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 96; xx++)
                mem[yy*96 + xx] = (xx <= 2 || xx >= 93 || (xx >= 12 && xx <= 14 && yy >= 13 && yy <= 24))
                                  ? 16'hFFFF : 16'h0000;
        for (int a = 6144; a < 8192; a++) mem[a] = 16'h0000;
        mem[44*96 + 29] = 16'h07E0;

        vt[0]  = '{3, 20, 40, -1, 1, 21, 40, 12, GOAL_ON};
        vt[1]  = '{2,  3, 40, -1, 0,  3, 40, 12, 0};
        vt[2]  = '{2,  0, 10, -1, 0,  0, 10,  2, 0};
        vt[3]  = '{3,  3, 16,  3, 0,  3, 16, 12, 0};
        vt[4]  = '{0, 20,  0, -1, 0, 20,  0,  2, 0};
        vt[5]  = '{1, 20, 55, -1, 0, 20, 55,  2, 0};
        vt[6]  = '{1, 20, 54, -1, 1, 20, 55, 12, 0};
        vt[7]  = '{3, 86, 20, -1, 0, 86, 20, 12, 0};
        vt[8]  = '{3, 87, 20, -1, 0, 87, 20,  2, 0};
        vt[9]  = '{0, 12, 25, -1, 0, 12, 25, 12, 0};
        vt[10] = '{1,  5,  4, -1, 0,  5,  4, 12, 0};
        vt[11] = '{0,  5,  4, -1, 1,  5,  3, 12, 0};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset_init");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);

        for (int i = 0; i < 12; i++) begin
            model(vt[i].d, vt[i].x, vt[i].y, ok, nx, ny, lat, goal);
            run_move($sformatf("vec%0d", i), vt[i].d, vt[i].x, vt[i].y, vt[i].inj,
                     vt[i].ok, vt[i].nx, vt[i].ny, vt[i].lat, vt[i].goal);
        end

        // reset during the 4th SCAN cycle
        @(negedge clk);
        bus.req = 1'b1; bus.dir = 2'd3; bus.px = 7'd20; bus.py = 6'd40;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset_scan");
        reset = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        chk("reset_scan_no_done", dones, 0);
        model(3, 20, 40, ok, nx, ny, lat, goal);
        run_move("after_reset", 3, 20, 40, -1, ok, nx, ny, lat, goal);

        for (int n = 0; n < 60; n++) begin
            d = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 5));
            x = (r == 0) ? 0 : (r == 1) ? 87 : (r == 2) ? 3 : int'($urandom_range(0, 87));
            r = int'($urandom_range(0, 5));
            y = (r == 0) ? 0 : (r == 1) ? 55 : (r == 2) ? 25 : int'($urandom_range(0, 55));
            model(d, x, y, ok, nx, ny, lat, goal);
            run_move($sformatf("rnd%0d", n), d, x, y, (n % 3 == 0) ? 2 : -1, ok, nx, ny, lat, goal);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
